pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The module SHALL have one clock `clk` and an asynchronous, active-high reset `reset`; both are fixed.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- idex_memread  in  1  load in ID/EX.
- idex_rd  in  5  destination register in ID/EX.
- ifid_rs1  in  5  source 1 of instruction in IF/ID.
- ifid_rs2  in  5  source 2 of instruction in IF/ID.
- branch_taken  in  1  EX-stage branch/jump redirect.
- id_halt  in  1  halt instruction in IF/ID.
- wb_halt  in  1  halt flag in MEM/WB.
- dmem_req  in  1  EX/MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register loads a bubble.
- idex_en  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX register loads a bubble.
- exmem_en  out  1  EX/MEM register enable.
- memwb_flush  out  1  MEM/WB register loads a bubble.
- halted  out  1  core stopped.
- state  out  2  FSM state: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3.
- stall_cnt  out  16  saturating count of stall cycles.
- flush_cnt  out  16  saturating count of branch flushes.

Function
REQ-003 Outputs SHALL be combinational from `state` and the current inputs; `state` and the counters SHALL be registered.
REQ-004 A flush SHALL override the enable of the same register.
REQ-005 The default (no hazard) SHALL be: all enables 1, all flushes 0.
REQ-006 Memory stall `mw = dmem_req & !dmem_ready` SHALL have highest priority in RUN and DRAIN. When `mw` is 1:
- pc_en, ifid_en, idex_en and exmem_en SHALL be 0.
- memwb_flush SHALL be 1.
- branch and load-use handling SHALL be ignored that cycle.
REQ-007 Branch redirect (`branch_taken`=1, no `mw`) SHALL produce: ifid_flush=1, idex_flush=1, pc_en=1.
- Branch redirect SHALL take priority over load-use and over `id_halt`.
REQ-008 Load-use (`idex_memread`=1 and `idex_rd`!=0 and (`idex_rd`==`ifid_rs1` or `idex_rd`==`ifid_rs2`)), with no branch and no `mw`, SHALL produce: pc_en=0, ifid_en=0, idex_flush=1.
- This SHALL be a single-cycle stall per hazard occurrence.
REQ-009 RUN->MEM_WAIT SHALL occur when `mw`=1; MEM_WAIT->RUN SHALL occur on the first cycle with `dmem_ready`=1 (outputs that cycle per REQ-005 to REQ-008).
REQ-010 RUN->DRAIN SHALL occur when `id_halt`=1 with no `mw` and no `branch_taken`.
- The halt instruction SHALL advance to ID/EX that cycle.
REQ-011 In DRAIN: pc_en=0, ifid_flush=1; downstream registers SHALL advance normally except during `mw` (REQ-006).
- `branch_taken` and load-use SHALL be ignored in DRAIN.
- `id_halt` SHALL be ignored in DRAIN.
REQ-012 DRAIN->HALTED SHALL occur when `wb_halt`=1.
REQ-013 MEM_WAIT with `id_halt`=1 SHALL return to DRAIN rather than RUN once `dmem_ready`=1, following the REQ-010 conditions.
REQ-014 In HALTED, the outputs SHALL be:
- all enables 0, ifid_flush=1, idex_flush=1, memwb_flush=1, halted=1.
- HALTED SHALL be left only by reset.
REQ-015 `stall_cnt` SHALL increment by 1 in every cycle with `mw` or load-use asserted, in any non-HALTED state, saturating at 16'hFFFF.
REQ-016 `flush_cnt` SHALL increment on each cycle REQ-007 applies, saturating at 16'hFFFF with no wrap.
REQ-017 Simultaneous load-use and branch_taken SHALL count only as a flush.

Reset
REQ-018 Reset assertion SHALL immediately, without waiting for `clk`, force:
- state=RUN, stall_cnt=0, flush_cnt=0, halted=0.
- pc_en=0, ifid_en=0, idex_en=0, exmem_en=0, ifid_flush=1, idex_flush=1, memwb_flush=1.
REQ-019 After reset deassertion, the first rising edge SHALL evaluate in RUN.
REQ-020 Reset asserted in any state, including mid-MEM_WAIT or mid-DRAIN, SHALL abandon that state with no residual stall.

Verification
REQ-021 Load-use: idex_memread=1, idex_rd=5, ifid_rs1=5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
- Repeating the stimulus with idex_rd=0 -> no stall.
REQ-022 Branch and load-use together: branch_taken=1 with load-use true -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
REQ-023 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> state=1 for 3 cycles, exmem_en=0, memwb_flush=1; stall_cnt=3; state=0 on the ready cycle.
REQ-024 Halt drain: id_halt=1 -> state=2, pc_en=0, ifid_flush=1; wb_halt=1 three cycles later -> state=3, halted=1, all enables 0.
- A branch_taken during DRAIN -> no flush_cnt change.
REQ-025 Counter saturation: hold mw for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-026 Async reset during MEM_WAIT, between clock edges -> outputs per REQ-018 immediately; state=0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard-controller signal bundle
// Pipeline hazard inputs, stage-register controls and status; master drives hazards, slave is the controller.
interface pipe_hazard_ctrl_if;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        branch_taken;
  logic        id_halt;
  logic        wb_halt;
  logic        dmem_req;
  logic        dmem_ready;

  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        memwb_flush;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output idex_memread, idex_rd, ifid_rs1, ifid_rs2, branch_taken,
           id_halt, wb_halt, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, halted, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, branch_taken,
           id_halt, wb_halt, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard and halt controller
// Resolves memory stalls, branch redirects, load-use stalls and halt draining; counts stalls and flushes.
module pipe_hazard_ctrl (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic mw;
  logic load_use;
  logic mem_stall;
  logic lu_stall;
  logic br_flush;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted;

  assign mw       = bus.dmem_req & ~bus.dmem_ready;
  assign load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                    ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));

  always_comb begin
    state_d     = state_q;
    mem_stall   = 1'b0;
    lu_stall    = 1'b0;
    br_flush    = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        // While waiting, the outstanding access is held until ready, whatever dmem_req does.
        mem_stall = (state_q == MEM_WAIT) ? ~bus.dmem_ready : mw;
        if (mem_stall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          state_d     = MEM_WAIT;
        end else if (bus.branch_taken) begin
          br_flush   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = RUN;
        end else if (load_use) begin
          // A stalled halt cannot reach ID/EX, so the drain starts once the hazard clears.
          lu_stall   = 1'b1;
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          state_d    = RUN;
        end else if (bus.id_halt) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end

      DRAIN: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        mem_stall  = mw;
        if (mw) begin
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end
        if (bus.wb_halt) begin
          state_d = HALTED;
        end
      end

      HALTED: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_en     = 1'b0;
        idex_flush  = 1'b1;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
        halted      = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Reset freezes the pipe immediately, independent of the clock.
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      halted      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((mem_stall || lu_stall) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (br_flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_flush = memwb_flush;
  assign bus.halted      = halted;
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
